// File: rtl/ib_lut_update_loader.sv
// ib_lut_update_loader
// Streams one iteration's IB LUT contents into the CNU function RAMs f0..f3.
// Each accepted source word becomes one registered RAM write one cycle later:
// shared page address {frame, page}, write word, and a one-hot function
// write enable. Pages advance first, then functions.
// Optional build macro IB_LOADER_CHECKSUM_EN adds a modulo-256 sum of all
// accepted words, compared against chk_expect when the load completes.
module ib_lut_update_loader #(
  parameter int LUT_PORT_SIZE   = 2,
  parameter int BANK_NUM        = 2,
  parameter int ENTRY_ADDR      = 4,
  parameter int MULTI_FRAME_NUM = 2,
  parameter int CN_FUNC_NUM     = 4
) (
  input  logic                              write_clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic                              frame_sel,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data,
  output logic [CN_FUNC_NUM-1:0]            ib_ram_we,
  output logic                              busy,
`ifdef IB_LOADER_CHECKSUM_EN
  input  logic [7:0]                        chk_expect,
  output logic                              chk_err,
`endif
  output logic                              done
);

  localparam int DATA_W   = LUT_PORT_SIZE * BANK_NUM;
  localparam int PAGE_W   = ENTRY_ADDR - 1;
  localparam int PAGE_NUM = 2 ** PAGE_W;
  localparam int FRAME_W  = (MULTI_FRAME_NUM > 1) ? $clog2(MULTI_FRAME_NUM) : 1;
  localparam int FUNC_W   = (CN_FUNC_NUM > 1) ? $clog2(CN_FUNC_NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   w_start_acc;
  logic                   w_accept;
  logic                   w_ready;
  logic                   w_page_last;
  logic                   w_func_last;
  logic [FRAME_W-1:0]     r_frame;
  logic [PAGE_W-1:0]      r_page_cnt;
  logic [FUNC_W-1:0]      r_func_cnt;
  logic [ENTRY_ADDR-1:0]  r_page_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [CN_FUNC_NUM-1:0] r_we;
  logic [CN_FUNC_NUM-1:0] w_we_onehot;
  logic                   r_busy;
  logic                   r_done;

  assign w_page_last = (r_page_cnt == PAGE_W'(PAGE_NUM - 1));
  assign w_func_last = (r_func_cnt == FUNC_W'(CN_FUNC_NUM - 1));
  assign w_we_onehot = {{(CN_FUNC_NUM-1){1'b0}}, 1'b1} << r_func_cnt;

  // State register.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic plus handshake decode; only LOAD accepts words.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_accept     = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready  = 1'b1;
        w_accept = s_valid;
        if (s_valid && w_page_last && w_func_last) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Frame latch and page/function counters; pages wrap before functions step.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_frame    <= '0;
      r_page_cnt <= '0;
      r_func_cnt <= '0;
    end else if (w_start_acc) begin
      r_frame    <= FRAME_W'(frame_sel);
      r_page_cnt <= '0;
      r_func_cnt <= '0;
    end else if (w_accept) begin
      r_page_cnt <= r_page_cnt + 1'b1;
      if (w_page_last) r_func_cnt <= r_func_cnt + 1'b1;
    end
  end

  // Write port: enable pulses for exactly one cycle per accepted word.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_page_addr <= '0;
      r_wdata     <= '0;
      r_we        <= '0;
    end else begin
      r_we <= w_accept ? w_we_onehot : '0;
      if (w_accept) begin
        r_page_addr <= {r_frame, r_page_cnt};
        r_wdata     <= s_data;
      end
    end
  end

  // Status flags: busy spans start..DONE, done pulses the cycle after DONE.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_start_acc)                r_busy <= 1'b1;
      else if (r_state == ST_DONE)    r_busy <= 1'b0;
    end
  end

`ifdef IB_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] r_chk_expect;
  logic       r_chk_err;

  // Running checksum; verdict is taken in DONE and held until the next start.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_sum        <= '0;
      r_chk_expect <= '0;
      r_chk_err    <= 1'b0;
    end else if (w_start_acc) begin
      r_sum        <= '0;
      r_chk_expect <= chk_expect;
      r_chk_err    <= 1'b0;
    end else begin
      if (w_accept)             r_sum     <= r_sum + 8'(s_data);
      if (r_state == ST_DONE)   r_chk_err <= (r_sum != r_chk_expect);
    end
  end

  assign chk_err = r_chk_err;
`endif

  assign s_ready        = w_ready;
  assign page_addr_ram  = r_page_addr;
  assign ram_write_data = r_wdata;
  assign ib_ram_we      = r_we;
  assign busy           = r_busy;
  assign done           = r_done;

endmodule
